// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the MEM-stage load/store responder.
package data_mem_responder_pkg;

  // Access size, encoded exactly as the load/store funct3 field.
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } resp_state_t;

  // Size legality for the direction plus natural-alignment check.
  // The address range check depends on DEPTH and lives in the responder.
  function automatic logic access_err(input logic       we,
                                      input logic [2:0] size,
                                      input logic [1:0] lsb);
    logic err;
    case (size)
      MEM_B:   err = 1'b0;
      MEM_H:   err = lsb[0];
      MEM_W:   err = |lsb;
      MEM_BU:  err = we;
      MEM_HU:  err = we | lsb[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Pick the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [31:0] extend_load(input logic [2:0]  size,
                                              input logic [31:0] word,
                                              input logic [1:0]  lsb);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {lsb, 3'b000};
    case (size)
      MEM_B:   result = {{24{shifted[7]}}, shifted[7:0]};
      MEM_BU:  result = {24'h0, shifted[7:0]};
      MEM_H:   result = {{16{shifted[15]}}, shifted[15:0]};
      MEM_HU:  result = {16'h0, shifted[15:0]};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_en_ram.sv
// Word-organised data array with per-byte write enables, synchronous write
// and combinational read.
module data_mem_responder_byte_en_ram #(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write into the addressed word.
  // NOTE: the array has no reset branch; contents survive rst_n, and a reset
  // loop over DEPTH words would prevent mapping onto block RAM.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage responder: accepts one load/store at a time, models the access
// latency, performs the byte/half/word access and returns a response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int    DEPTH        = 1024,
  parameter int    LOAD_PERIOD  = 2,
  parameter int    STORE_PERIOD = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_we_in,
  input  logic [2:0]  req_size_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  output logic        resp_valid_out,
  input  logic        resp_ready_in,
  output logic [31:0] resp_rdata_out,
  output logic        resp_err_out
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MAX_P = (LOAD_PERIOD > STORE_PERIOD) ? LOAD_PERIOD : STORE_PERIOD;
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] LOAD_CNT  = CNT_W'(LOAD_PERIOD - 1);
  localparam logic [CNT_W-1:0] STORE_CNT = CNT_W'(STORE_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [31:0]      DEPTH_W   = 32'(DEPTH);

  resp_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic [2:0]       lat_size;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;

  // The operation being finished: the live request when a zero-latency access
  // enters RESP straight from IDLE, otherwise the latched one.
  logic             op_we;
  logic [2:0]       op_size;
  logic [31:0]      op_addr;
  logic [31:0]      op_wdata;
  logic             op_err;
  logic [3:0]       op_be;
  logic [31:0]      op_lanes;
  logic [31:0]      ram_rdata;
  logic [3:0]       ram_we;
  logic [31:0]      resp_data;
  logic             accept;
  logic [CNT_W-1:0] start_cnt;
  logic             enter_resp;

  assign accept     = (state == ST_IDLE) && req_valid_in && req_ready_out;
  assign start_cnt  = req_we_in ? STORE_CNT : LOAD_CNT;
  assign enter_resp = (accept && (start_cnt == '0)) ||
                      ((state == ST_WAIT) && (cnt == CNT_ONE));

  // Operand select, error check, store lane steering and load extension.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    op_we    = lat_we;
    op_size  = lat_size;
    op_addr  = lat_addr;
    op_wdata = lat_wdata;
    if (state == ST_IDLE) begin
      op_we    = req_we_in;
      op_size  = req_size_in;
      op_addr  = req_addr_in;
      op_wdata = req_wdata_in;
    end

    op_err = access_err(op_we, op_size, op_addr[1:0]) |
             ({2'b00, op_addr[31:2]} >= DEPTH_W);

    op_be    = 4'b1111;
    op_lanes = op_wdata;
    case (op_size)
      MEM_B: begin
        op_be    = 4'b0001 << op_addr[1:0];
        op_lanes = {4{op_wdata[7:0]}};
      end
      MEM_H: begin
        op_be    = op_addr[1] ? 4'b1100 : 4'b0011;
        op_lanes = {2{op_wdata[15:0]}};
      end
      default: ;
    endcase

    ram_we    = (enter_resp && op_we && !op_err) ? op_be : 4'b0000;
    resp_data = (op_we || op_err) ? 32'h0 :
                extend_load(op_size, ram_rdata, op_addr[1:0]);
  end

  data_mem_responder_byte_en_ram #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk_in),
    .we    (ram_we),
    .addr  (op_addr[AW+1:2]),
    .wdata (op_lanes),
    .rdata (ram_rdata)
  );

  // Request/latency/response FSM with registered handshake outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      lat_we         <= 1'b0;
      lat_size       <= 3'b000;
      lat_addr       <= 32'h0;
      lat_wdata      <= 32'h0;
      req_ready_out  <= 1'b1;
      resp_valid_out <= 1'b0;
      resp_rdata_out <= 32'h0;
      resp_err_out   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_we        <= req_we_in;
            lat_size      <= req_size_in;
            lat_addr      <= req_addr_in;
            lat_wdata     <= req_wdata_in;
            req_ready_out <= 1'b0;
            if (start_cnt == '0) begin
              state          <= ST_RESP;
              resp_valid_out <= 1'b1;
              resp_rdata_out <= resp_data;
              resp_err_out   <= op_err;
            end else begin
              state <= ST_WAIT;
              cnt   <= start_cnt;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state          <= ST_RESP;
            resp_valid_out <= 1'b1;
            resp_rdata_out <= resp_data;
            resp_err_out   <= op_err;
          end
        end
        ST_RESP: begin
          if (resp_ready_in) begin
            state          <= ST_IDLE;
            req_ready_out  <= 1'b1;
            resp_valid_out <= 1'b0;
            resp_rdata_out <= 32'h0;
            resp_err_out   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (LOAD/STORE periods 2/2 and 1/3) share
// clock and reset; a byte-addressed memory model predicts every response.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [2:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] resp_rdata[2];

  logic [31:0] mem_m [2][DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH(DEPTH), .LOAD_PERIOD(2), .STORE_PERIOD(2), .INIT_FILE("")
  ) dut_a (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid[0]), .req_ready_out(req_ready[0]),
    .req_we_in(req_we[0]), .req_size_in(req_size[0]),
    .req_addr_in(req_addr[0]), .req_wdata_in(req_wdata[0]),
    .resp_valid_out(resp_valid[0]), .resp_ready_in(resp_ready[0]),
    .resp_rdata_out(resp_rdata[0]), .resp_err_out(resp_err[0])
  );

  data_mem_responder #(
    .DEPTH(DEPTH), .LOAD_PERIOD(1), .STORE_PERIOD(3), .INIT_FILE("")
  ) dut_b (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid[1]), .req_ready_out(req_ready[1]),
    .req_we_in(req_we[1]), .req_size_in(req_size[1]),
    .req_addr_in(req_addr[1]), .req_wdata_in(req_wdata[1]),
    .resp_valid_out(resp_valid[1]), .resp_ready_in(resp_ready[1]),
    .resp_rdata_out(resp_rdata[1]), .resp_err_out(resp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int period(input int d, input logic we);
    if (d == 0) return 2;
    return we ? 3 : 1;
  endfunction

  function automatic logic exp_err(input logic we, input logic [2:0] size, input logic [31:0] addr);
    logic legal;
    if (we) legal = size inside {SZ_B, SZ_H, SZ_W};
    else    legal = size inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
    if (!legal) return 1'b1;
    if ((size == SZ_H || size == SZ_HU) && addr[0]) return 1'b1;
    if (size == SZ_W && addr[1:0] != 2'b00) return 1'b1;
    if ((addr >> 2) >= 32'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] get_byte(input int d, input logic [31:0] a);
    return mem_m[d][int'(a >> 2) % DEPTH][int'(a & 32'd3)*8 +: 8];
  endfunction

  task automatic set_byte(input int d, input logic [31:0] a, input logic [7:0] v);
    mem_m[d][int'(a >> 2) % DEPTH][int'(a & 32'd3)*8 +: 8] = v;
  endtask

  function automatic logic [31:0] exp_load(input int d, input logic [2:0] size, input logic [31:0] addr);
    logic [7:0] b0, b1;
    b0 = get_byte(d, addr);
    b1 = get_byte(d, addr + 32'd1);
    case (size)
      SZ_B:    return {{24{b0[7]}}, b0};
      SZ_BU:   return {24'h0, b0};
      SZ_H:    return {{16{b1[7]}}, b1, b0};
      SZ_HU:   return {16'h0, b1, b0};
      default: return mem_m[d][int'(addr >> 2) % DEPTH];
    endcase
  endfunction

  // One full transaction: accept, latency, response contents, optional
  // back-pressure for 'hold' cycles, then the response handshake.
  task automatic xact(input int d, input logic we, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                      output logic [31:0] got_rdata, output logic got_err);
    logic [31:0] e_rdata;
    logic        e_err;
    int          lat;
    @(negedge clk);
    check($sformatf("d%0d ready_before_req", d), 32'(req_ready[d]), 32'd1);
    e_err   = exp_err(we, size, addr);
    e_rdata = (we || e_err) ? 32'h0 : exp_load(d, size, addr);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_size[d]  = size;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    resp_ready[d] = (hold == 0);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!resp_valid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("d%0d latency a=%h", d, addr), 32'(lat), 32'(period(d, we)));
    check($sformatf("d%0d rdata a=%h sz=%0d we=%0d", d, addr, size, we), resp_rdata[d], e_rdata);
    check($sformatf("d%0d err a=%h sz=%0d we=%0d", d, addr, size, we), 32'(resp_err[d]), 32'(e_err));
    check($sformatf("d%0d ready_in_resp", d), 32'(req_ready[d]), 32'd0);
    got_rdata = resp_rdata[d];
    got_err   = resp_err[d];
    if (we && !e_err) begin
      for (int k = 0; k < (1 << size[1:0]); k++)
        set_byte(d, addr + 32'(k), wdata[8*k +: 8]);
    end
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        req_valid[d] = 1'b1;
        req_we[d]    = 1'b1;
        req_size[d]  = SZ_W;
        req_addr[d]  = 32'h10;
        req_wdata[d] = 32'h5555_AAAA;
      end
      @(posedge clk); #1;
      check($sformatf("d%0d hold valid", d), 32'(resp_valid[d]), 32'd1);
      check($sformatf("d%0d hold rdata", d), resp_rdata[d], e_rdata);
      check($sformatf("d%0d hold ready", d), 32'(req_ready[d]), 32'd0);
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    check($sformatf("d%0d post valid", d), 32'(resp_valid[d]), 32'd0);
    check($sformatf("d%0d post rdata", d), resp_rdata[d], 32'h0);
    check($sformatf("d%0d post err", d), 32'(resp_err[d]), 32'd0);
    check($sformatf("d%0d post ready", d), 32'(req_ready[d]), 32'd1);
    resp_ready[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    logic [31:0] prior;

    rst_n      = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    resp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      req_size[d]  = SZ_W;
      req_addr[d]  = 32'h0;
      req_wdata[d] = 32'h0;
    end

    // Reset state.
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d rst ready", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("d%0d rst valid", d), 32'(resp_valid[d]), 32'd0);
      check($sformatf("d%0d rst rdata", d), resp_rdata[d], 32'h0);
      check($sformatf("d%0d rst err", d), 32'(resp_err[d]), 32'd0);
    end
    #8 rst_n = 1'b1;

    // Give words 0..15 known contents in both arrays.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        xact(d, 1'b1, SZ_W, 32'(w * 4), $urandom, 0, r, e);

    // Directed sequence on the 2/2 responder.
    xact(0, 1'b1, SZ_W, 32'h10, 32'hDEAD_BEEF, 0, r, e);
    check("sw ack rdata", r, 32'h0);
    xact(0, 1'b0, SZ_W, 32'h10, 32'h0, 0, r, e);
    check("lw deadbeef", r, 32'hDEAD_BEEF);
    xact(0, 1'b1, SZ_B, 32'h13, 32'h1234_5680, 0, r, e);
    xact(0, 1'b0, SZ_B, 32'h13, 32'h0, 0, r, e);
    check("lb 0x13", r, 32'hFFFF_FF80);
    xact(0, 1'b0, SZ_BU, 32'h13, 32'h0, 0, r, e);
    check("lbu 0x13", r, 32'h0000_0080);
    xact(0, 1'b0, SZ_W, 32'h10, 32'h0, 0, r, e);
    check("lw after sb", r, 32'h80AD_BEEF);
    xact(0, 1'b0, SZ_H, 32'h11, 32'h0, 0, r, e);
    check("lh misaligned err", 32'(e), 32'd1);
    xact(0, 1'b1, SZ_W, 32'h1000, 32'h0BAD_0BAD, 0, r, e);
    check("sw out of range err", 32'(e), 32'd1);
    xact(0, 1'b0, SZ_W, 32'h0, 32'h0, 0, r, e);
    xact(0, 1'b1, SZ_H, 32'h12, 32'hBEEF_1234, 0, r, e);
    xact(0, 1'b0, SZ_W, 32'h10, 32'h0, 0, r, e);
    check("lw after sh", r, 32'h1234_BEEF);
    xact(0, 1'b1, SZ_BU, 32'h14, 32'h1, 0, r, e);
    check("sbu illegal err", 32'(e), 32'd1);
    xact(0, 1'b0, SZ_W, 32'h10, 32'h0, 5, r, e);

    // Latency on the 1/3 responder.
    xact(1, 1'b0, SZ_W, 32'h10, 32'h0, 0, r, e);
    xact(1, 1'b1, SZ_W, 32'h20, 32'h0123_4567, 0, r, e);
    xact(1, 1'b0, SZ_HU, 32'h22, 32'h0, 0, r, e);
    check("lhu 0x22", r, 32'h0000_0123);

    // Reset mid-WAIT of a store: outputs clear at once, no write lands.
    prior = mem_m[1][9];
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_size[1]  = SZ_W;
    req_addr[1]  = 32'h24;
    req_wdata[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("mid wait ready", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async rst ready", 32'(req_ready[1]), 32'd1);
    check("async rst valid", 32'(resp_valid[1]), 32'd0);
    check("async rst rdata", resp_rdata[1], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    xact(1, 1'b0, SZ_W, 32'h24, 32'h0, 0, r, e);
    check("lw after aborted sw", r, prior);

    // Randomised mix on both responders.
    for (int n = 0; n < 300; n++) begin
      int          d;
      logic [31:0] a;
      d = n % 2;
      a = ($urandom_range(99) < 8) ? (32'h1000 + 32'($urandom_range(63)))
                                   : 32'($urandom_range(63));
      xact(d, 1'(($urandom >> 3) & 1), 3'($urandom_range(7)), a, $urandom,
           $urandom_range(2), r, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
